// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage of the 16-bit pipeline.
//   word_t        : 16-bit machine word (instructions and addresses)
//   BUBBLE_WORD   : instruction encoding with no side effects, shown when IF/ID is empty
//   RESET_PC_DEFAULT : default PC after reset
//   fetch_state_e : BOOT (post-reset idle), FETCH (request out), HOLD (word parked, decode stalled)
//   pc_inc        : sequential PC step, wraps FFFF -> 0000
package instr_fetch_pkg;

    typedef logic [15:0] word_t;

    localparam word_t BUBBLE_WORD      = 16'hF000;
    localparam word_t RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    function automatic word_t pc_inc(input word_t pc);
        return pc + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid register for the fetch stage: parks a fetched word and its
// address when the memory completes a request while decode is stalled.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   load                  : capture load_word/load_addr, mark entry valid
//   drain                 : entry has been moved to IF/ID, mark empty
//   clear                 : discard entry (redirect); wins over load and drain
//   load_word, load_addr  : word and address to capture
//   word, addr, valid     : stored entry
module fetch_skid
    import instr_fetch_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  logic  drain,
    input  logic  clear,
    input  word_t load_word,
    input  word_t load_addr,
    output word_t word,
    output word_t addr,
    output logic  valid
);

    word_t word_reg;
    word_t addr_reg;
    logic  valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_reg  <= '0;
            addr_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (clear) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            word_reg  <= load_word;
            addr_reg  <= load_addr;
            valid_reg <= 1'b1;
        end else if (drain) begin
            valid_reg <= 1'b0;
        end
    end

    assign word  = word_reg;
    assign addr  = addr_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage. Holds the PC, requests words from instruction
// memory over a ready/valid handshake and registers the fetched word plus
// its address into the IF/ID boundary. Redirects come from decode (jump)
// and execute (flush); flush wins.
// Parameters:
//   RESET_PC : PC loaded on reset
//   BUBBLE   : instruction word presented while instr_valid is low
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   stall               : decode cannot accept, hold IF/ID
//   flush, flush_PC     : execute mispredict redirect and its target
//   jump, new_PC        : decode redirect and its target
//   i_mem_re, i_mem_addr: fetch request and word address (decoded from registers only)
//   i_mem_rdata, i_mem_rdy : returned word, request completes this cycle
//   instr, i_addr, instr_valid : IF/ID register contents
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEFAULT,
    parameter word_t BUBBLE   = BUBBLE_WORD
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  stall,
    input  logic  flush,
    input  word_t flush_PC,
    input  logic  jump,
    input  word_t new_PC,
    output logic  i_mem_re,
    output word_t i_mem_addr,
    input  word_t i_mem_rdata,
    input  logic  i_mem_rdy,
    output word_t instr,
    output word_t i_addr,
    output logic  instr_valid
);

    fetch_state_e state_reg, state_next;
    word_t        pc_reg, pc_next;
    word_t        instr_reg, instr_next;
    word_t        i_addr_reg, i_addr_next;
    logic         instr_valid_reg, instr_valid_next;
    // squash: a redirect arrived while a request was outstanding; the word
    // returned for that request must be dropped and the PC taken from pend_pc.
    logic         squash_reg, squash_next;
    word_t        pend_pc_reg, pend_pc_next;

    logic         redirect;
    word_t        redirect_pc;

    logic         skid_load, skid_drain, skid_clear;
    word_t        skid_word, skid_addr;
    logic         skid_valid;

    assign redirect    = flush | jump;
    assign redirect_pc = flush ? flush_PC : new_PC;

    fetch_skid u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (skid_load),
        .drain     (skid_drain),
        .clear     (skid_clear),
        .load_word (i_mem_rdata),
        .load_addr (pc_reg),
        .word      (skid_word),
        .addr      (skid_addr),
        .valid     (skid_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= BOOT;
            pc_reg          <= RESET_PC;
            instr_reg       <= BUBBLE;
            i_addr_reg      <= '0;
            instr_valid_reg <= 1'b0;
            squash_reg      <= 1'b0;
            pend_pc_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            instr_reg       <= instr_next;
            i_addr_reg      <= i_addr_next;
            instr_valid_reg <= instr_valid_next;
            squash_reg      <= squash_next;
            pend_pc_reg     <= pend_pc_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        instr_next       = instr_reg;
        i_addr_next      = i_addr_reg;
        instr_valid_next = instr_valid_reg;
        squash_next      = squash_reg;
        pend_pc_next     = pend_pc_reg;
        skid_load        = 1'b0;
        skid_drain       = 1'b0;
        skid_clear       = 1'b0;

        case (state_reg)
            BOOT: begin
                state_next = FETCH;
                if (redirect) begin
                    pc_next = redirect_pc;
                end
            end

            FETCH: begin
                if (redirect) begin
                    if (i_mem_rdy) begin
                        // Outstanding word completes now: drop it, go straight to target.
                        pc_next     = redirect_pc;
                        squash_next = 1'b0;
                    end else begin
                        // Address must stay put until rdy; remember where to go.
                        pend_pc_next = redirect_pc;
                        squash_next  = 1'b1;
                    end
                end else if (squash_reg) begin
                    if (i_mem_rdy) begin
                        pc_next     = pend_pc_reg;
                        squash_next = 1'b0;
                    end
                    if (!stall) begin
                        instr_next       = BUBBLE;
                        instr_valid_next = 1'b0;
                    end
                end else if (i_mem_rdy) begin
                    pc_next = pc_inc(pc_reg);
                    if (stall) begin
                        skid_load  = 1'b1;
                        state_next = HOLD;
                    end else begin
                        instr_next       = i_mem_rdata;
                        i_addr_next      = pc_reg;
                        instr_valid_next = 1'b1;
                    end
                end else if (!stall) begin
                    // Decode consumed the current word and nothing new arrived.
                    instr_next       = BUBBLE;
                    instr_valid_next = 1'b0;
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_next    = redirect_pc;
                    state_next = FETCH;
                end else if (!stall) begin
                    instr_next       = skid_word;
                    i_addr_next      = skid_addr;
                    instr_valid_next = skid_valid;
                    skid_drain       = 1'b1;
                    state_next       = FETCH;
                end
            end

            default: begin
                state_next = BOOT;
            end
        endcase

        // A redirect always empties IF/ID and the skid, whatever the state or stall.
        if (redirect) begin
            instr_next       = BUBBLE;
            instr_valid_next = 1'b0;
            skid_clear       = 1'b1;
        end
    end

    assign i_mem_re    = (state_reg == FETCH);
    assign i_mem_addr  = pc_reg;
    assign instr       = instr_reg;
    assign i_addr      = i_addr_reg;
    assign instr_valid = instr_valid_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch. Memory returns addr ^ 16'h5A5A.
// Expected delivered addresses are queued as stimulus is driven and popped
// whenever decode consumes a valid instruction (instr_valid && !stall).
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [15:0] flush_PC;
    logic        jump;
    logic [15:0] new_PC;
    logic        i_mem_re;
    logic [15:0] i_mem_addr;
    logic [15:0] i_mem_rdata;
    logic        i_mem_rdy;
    logic [15:0] instr;
    logic [15:0] i_addr;
    logic        instr_valid;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    instr_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .flush       (flush),
        .flush_PC    (flush_PC),
        .jump        (jump),
        .new_PC      (new_PC),
        .i_mem_re    (i_mem_re),
        .i_mem_addr  (i_mem_addr),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_rdy   (i_mem_rdy),
        .instr       (instr),
        .i_addr      (i_addr),
        .instr_valid (instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign i_mem_rdata = i_mem_addr ^ 16'h5A5A;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive point: just after the rising edge. Sample point: falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_present(input logic [15:0] a, input string tag);
        logic found;
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            @(negedge clk);
            if (instr_valid && i_addr == a) found = 1'b1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic push_run(input logic [15:0] first, input int count);
        logic [15:0] a;
        a = first;
        for (int k = 0; k < count; k++) begin
            exp_q.push_back(a);
            a = a + 16'd1;
        end
    endtask

    // Scoreboard: every instruction decode consumes must be the next expected one.
    always @(negedge clk) begin
        logic [15:0] exp_addr;
        if (rst_n && instr_valid && !stall) begin
            $display("tb: consume i_addr=%04h instr=%04h", i_addr, instr);
            check("sb_avail", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp_addr = exp_q.pop_front();
                check("sb_addr", 32'(i_addr), 32'(exp_addr));
                check("sb_instr", 32'(instr), 32'(exp_addr ^ 16'h5A5A));
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        flush_PC  = 16'h0000;
        jump      = 1'b0;
        new_PC    = 16'h0000;
        i_mem_rdy = 1'b1;

        // Reset state and first request timing
        push_run(16'h0000, 8);
        push_run(16'h0040, 3);
        @(negedge clk);
        check("rst_instr", 32'(instr), 32'h0000_F000);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_re", 32'(i_mem_re), 32'd0);
        check("rst_iaddr", 32'(i_addr), 32'd0);
        cyc(); rst_n = 1'b1;
        @(negedge clk);
        check("boot_re", 32'(i_mem_re), 32'd0);
        cyc();
        @(negedge clk);
        check("first_re", 32'(i_mem_re), 32'd1);
        check("first_addr", 32'(i_mem_addr), 32'h0000);
        check("first_valid", 32'(instr_valid), 32'd0);

        // Stall three cycles while the request for PC=4 completes
        wait_present(16'h0002, "wait_a2");
        cyc(); stall = 1'b1;
        @(negedge clk);
        check("stall_pc4", 32'(i_mem_addr), 32'h0004);
        check("stall0_iaddr", 32'(i_addr), 32'h0003);
        cyc();
        @(negedge clk);
        check("hold_re", 32'(i_mem_re), 32'd0);
        check("stall1_iaddr", 32'(i_addr), 32'h0003);
        cyc();
        @(negedge clk);
        check("stall2_iaddr", 32'(i_addr), 32'h0003);
        cyc(); stall = 1'b0;
        @(negedge clk);
        check("release_iaddr", 32'(i_addr), 32'h0003);
        cyc();
        @(negedge clk);
        check("skid_iaddr", 32'(i_addr), 32'h0004);
        check("skid_next_req", 32'(i_mem_addr), 32'h0005);
        cyc();
        @(negedge clk);
        check("after_skid_iaddr", 32'(i_addr), 32'h0005);

        // Jump to 0x40 while presenting addr 7
        wait_present(16'h0006, "wait_a6");
        cyc(); jump = 1'b1; new_PC = 16'h0040;
        @(negedge clk);
        check("jump_src", 32'(i_addr), 32'h0007);
        cyc(); jump = 1'b0;
        @(negedge clk);
        check("jump_bubble_instr", 32'(instr), 32'h0000_F000);
        check("jump_bubble_valid", 32'(instr_valid), 32'd0);
        check("jump_req", 32'(i_mem_addr), 32'h0040);
        cyc();
        @(negedge clk);
        check("jump_target", 32'(i_addr), 32'h0040);

        // Jump to 0x10, memory slow there, second jump to 0x20 mid-wait
        wait_present(16'h0041, "wait_a41");
        cyc(); jump = 1'b1; new_PC = 16'h0010;
        push_run(16'h0020, 3);
        @(negedge clk);
        check("j10_src", 32'(i_addr), 32'h0042);
        cyc(); jump = 1'b0; i_mem_rdy = 1'b0;
        @(negedge clk);
        check("wait1_addr", 32'(i_mem_addr), 32'h0010);
        cyc(); jump = 1'b1; new_PC = 16'h0020;
        @(negedge clk);
        check("wait2_addr", 32'(i_mem_addr), 32'h0010);
        cyc(); jump = 1'b0;
        @(negedge clk);
        check("wait3_addr", 32'(i_mem_addr), 32'h0010);
        check("wait3_re", 32'(i_mem_re), 32'd1);
        cyc();
        @(negedge clk);
        check("wait4_addr", 32'(i_mem_addr), 32'h0010);
        cyc(); i_mem_rdy = 1'b1;
        @(negedge clk);
        check("rdy_addr", 32'(i_mem_addr), 32'h0010);
        check("rdy_valid", 32'(instr_valid), 32'd0);
        cyc();
        @(negedge clk);
        check("pend_req", 32'(i_mem_addr), 32'h0020);
        check("dropped_valid", 32'(instr_valid), 32'd0);
        cyc();
        @(negedge clk);
        check("pend_target", 32'(i_addr), 32'h0020);

        // flush and jump in the same cycle: flush wins
        wait_present(16'h0021, "wait_a21");
        cyc(); flush = 1'b1; flush_PC = 16'h0080; jump = 1'b1; new_PC = 16'h0030;
        push_run(16'h0080, 3);
        @(negedge clk);
        check("fj_src", 32'(i_addr), 32'h0022);
        cyc(); flush = 1'b0; jump = 1'b0;
        @(negedge clk);
        check("fj_req", 32'(i_mem_addr), 32'h0080);
        check("fj_valid", 32'(instr_valid), 32'd0);
        cyc();
        @(negedge clk);
        check("fj_target", 32'(i_addr), 32'h0080);

        // PC wrap FFFF -> 0000
        wait_present(16'h0081, "wait_a81");
        cyc(); flush = 1'b1; flush_PC = 16'hFFFE;
        exp_q.push_back(16'hFFFE);
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h0000);
        @(negedge clk);
        check("wrap_src", 32'(i_addr), 32'h0082);
        cyc(); flush = 1'b0;
        @(negedge clk);
        check("wrap_req0", 32'(i_mem_addr), 32'hFFFE);
        cyc();
        @(negedge clk);
        check("wrap_req1", 32'(i_mem_addr), 32'hFFFF);
        cyc();
        @(negedge clk);
        check("wrap_req2", 32'(i_mem_addr), 32'h0000);
        check("wrap_iaddr", 32'(i_addr), 32'hFFFF);

        // Reset while a request is waiting; stale rdy after reset ignored
        cyc(); i_mem_rdy = 1'b0;
        @(negedge clk);
        check("pre_rst_iaddr", 32'(i_addr), 32'h0000);
        cyc();
        @(negedge clk);
        check("mid_wait_req", 32'(i_mem_addr), 32'h0001);
        #1 rst_n = 1'b0;
        #1;
        check("async_re", 32'(i_mem_re), 32'd0);
        check("async_valid", 32'(instr_valid), 32'd0);
        check("async_instr", 32'(instr), 32'h0000_F000);
        i_mem_rdy = 1'b1;
        push_run(16'h0000, 4);
        cyc(); rst_n = 1'b1;
        @(negedge clk);
        check("reboot_re", 32'(i_mem_re), 32'd0);
        cyc();
        @(negedge clk);
        check("restart_re", 32'(i_mem_re), 32'd1);
        check("restart_addr", 32'(i_mem_addr), 32'h0000);
        check("stale_rdy_valid", 32'(instr_valid), 32'd0);
        wait_present(16'h0002, "wait_r2");
        cyc(); i_mem_rdy = 1'b0;
        @(negedge clk);
        check("tail_iaddr", 32'(i_addr), 32'h0003);
        for (int k = 0; k < 3; k++) cyc();
        @(negedge clk);
        check("idle_valid", 32'(instr_valid), 32'd0);
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
